break_select_scan: RTL
======================

# break_select_scan

Sequential candidate scanner that sits directly downstream of the break value counter in the flip-selection path. For the currently chosen unsatisfied clause it accepts one (variable, break value) pair per candidate literal and tracks the greedy minimum, applying WalkSAT freebie and noise rules. It then presents a single selected variable to the flip logic over a valid/ready handshake.

## Interface
- NUM_CLAUSES, 20, clause count; break width BV_BITS = $clog2(NUM_CLAUSES).
- NUM_CANDIDATES, 3, maximum literals per clause; CNT_BITS = $clog2(NUM_CANDIDATES+1).
- VAR_ID_BITS, 8, variable index width.
- LFSR_SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'h0001.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start_i  in  1  begin selection; sampled only in IDLE.
- num_cand_i  in  CNT_BITS  literal count of clause, sampled with start_i.
- noise_thresh_i  in  16  noise probability, sampled with start_i.
- cand_valid_i  in  1  candidate present.
- cand_ready_o  out  1  scanner accepts candidate.
- cand_var_i  in  VAR_ID_BITS  candidate variable index.
- cand_break_i  in  BV_BITS  break value of candidate (unsigned).
- sel_valid_o  out  1  selection available.
- sel_ready_i  in  1  consumer takes selection.
- sel_var_o  out  VAR_ID_BITS  selected variable.
- sel_break_o  out  BV_BITS  break value of selected variable.
- sel_random_o  out  1  selection came from noise path.
- busy_o  out  1  state != IDLE.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: on start_i with num_cand_i != 0, latch n = min(num_cand_i, NUM_CANDIDATES), latch noise decision and random index, clear count/best and go to SCAN. start_i with num_cand_i == 0 is ignored. start_i in SCAN/DONE is ignored.
- LFSR: 16-bit Galois, taps 16,14,13,11, advances every cycle while reset is high.
- Noise decision at start: random = (noise_thresh_i == 16'hFFFF) || (lfsr < noise_thresh_i). Random index r = lfsr[7:0] mod n.
- SCAN: cand_ready_o = 1. Each accepted candidate (cand_valid_i && cand_ready_o) at index k = 0..n-1:
  - Greedy best updates if k == 0 or break < best_break (strict, so ties keep the lowest index).
  - Random pick captured when k == r.
  - Zero flag set if break == 0.
  - After the n-th accept, go to DONE.
- All n candidates are always consumed; there is no early exit, so the upstream stays aligned.
- Result selection in DONE:
  - If the zero flag is set, output the greedy pick with sel_random_o = 0 (freebie overrides noise).
  - Else if random, output the random pick with sel_random_o = 1.
  - Else output the greedy pick.
- DONE: sel_valid_o = 1 and outputs stable until sel_ready_i; on handshake return to IDLE.

## Timing
- Reset (reset == 0 at clk edge):
  - State goes to IDLE.
  - All outputs are 0: cand_ready_o, sel_valid_o, sel_var_o, sel_break_o, sel_random_o, busy_o.
  - LFSR = seed.
- Reset asserted mid-SCAN or mid-DONE aborts the selection; no sel_valid_o is produced.
- start_i at edge t: SCAN from t+1 (cand_ready_o high), busy_o high from t+1.
- With cand_valid_i held high, candidates are accepted at t+1..t+n. sel_valid_o is high from t+n+1, so minimum latency from start to result is n+1 cycles.
- Gaps in cand_valid_i stall SCAN without loss of state.
- Handshake at edge d (sel_valid_o && sel_ready_i): IDLE at d+1. The earliest next start is sampled at d+1.
- sel_ready_i high before DONE has no effect.
- Outputs are registered; no combinational path from inputs to sel_* or cand_ready_o.

## Test plan
- Reset, then noise_thresh=0, n=3, breaks (var 5:3, var 9:1, var 2:4) -> sel_var=9, sel_break=1, sel_random=0, sel_valid at start+4.
- Tie: breaks (7:2, 8:2, 3:2), thresh=0 -> sel_var=7, sel_break=2.
- Freebie: thresh=16'hFFFF, breaks (4:3, 6:0, 1:5) -> sel_var=6, sel_break=0, sel_random=0.
- Noise: thresh=16'hFFFF, breaks (4:3, 6:2, 1:5), r from a model LFSR seeded 16'hACE1 -> sel_var = candidate r, sel_random=1; repeat 100 runs matching the model.
- Backpressure/stall:
  - cand_valid_i toggled every other cycle with sel_ready_i low for 5 cycles -> outputs stable, one accept per valid.
  - start_i pulses during SCAN/DONE are ignored.
- Reset mid-SCAN after 2 candidates -> all outputs 0 next cycle. A new start with n=1 (var 11:0) -> sel_var=11.

Source files
------------

// File: rtl/break_select_scan.sv
// break_select_scan: sequential WalkSAT candidate scanner.
// Consumes one (variable, break value) pair per literal of the chosen
// clause, tracks the greedy minimum, applies freebie and noise rules,
// and offers one selected variable over a valid/ready handshake.
//
// Ports:
//   clk, reset        clock and synchronous active-low reset
//   start_i           begin a selection (IDLE only)
//   num_cand_i        literal count of the clause, sampled with start_i
//   noise_thresh_i    noise probability, sampled with start_i
//   cand_valid_i/cand_ready_o/cand_var_i/cand_break_i  candidate stream
//   sel_valid_o/sel_ready_i/sel_var_o/sel_break_o/sel_random_o  result
//   busy_o            scanner not idle
module break_select_scan #(
    parameter int          NUM_CLAUSES    = 20,
    parameter int          NUM_CANDIDATES = 3,
    parameter int          VAR_ID_BITS    = 8,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    localparam int         BV_BITS        = $clog2(NUM_CLAUSES),
    localparam int         CNT_BITS       = $clog2(NUM_CANDIDATES + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_i,
    input  logic [CNT_BITS-1:0]    num_cand_i,
    input  logic [15:0]            noise_thresh_i,
    input  logic                   cand_valid_i,
    output logic                   cand_ready_o,
    input  logic [VAR_ID_BITS-1:0] cand_var_i,
    input  logic [BV_BITS-1:0]     cand_break_i,
    output logic                   sel_valid_o,
    input  logic                   sel_ready_i,
    output logic [VAR_ID_BITS-1:0] sel_var_o,
    output logic [BV_BITS-1:0]     sel_break_o,
    output logic                   sel_random_o,
    output logic                   busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ?
                                   16'h0001 : LFSR_SEED;
    localparam logic [CNT_BITS-1:0] NMAX = CNT_BITS'(NUM_CANDIDATES);

    state_t                 state_q, state_d;
    logic [15:0]            lfsr_q, lfsr_d;
    logic [CNT_BITS-1:0]    n_q, n_d;
    logic [CNT_BITS-1:0]    cnt_q, cnt_d;
    logic [CNT_BITS-1:0]    ridx_q, ridx_d;
    logic                   rnd_q, rnd_d;
    logic                   zero_q, zero_d;
    logic [VAR_ID_BITS-1:0] bvar_q, bvar_d;
    logic [BV_BITS-1:0]     bbrk_q, bbrk_d;
    logic [VAR_ID_BITS-1:0] rvar_q, rvar_d;
    logic [BV_BITS-1:0]     rbrk_q, rbrk_d;
    logic [VAR_ID_BITS-1:0] svar_q, svar_d;
    logic [BV_BITS-1:0]     sbrk_q, sbrk_d;
    logic                   srnd_q, srnd_d;

    // Start-time decisions taken from the current LFSR value.
    logic [CNT_BITS-1:0] n_start;
    logic [7:0]          div;
    logic [CNT_BITS-1:0] r_start;
    logic                rnd_start;

    assign n_start   = (num_cand_i > NMAX) ? NMAX : num_cand_i;
    assign div       = (n_start == '0) ? 8'd1 : 8'(n_start);
    assign r_start   = CNT_BITS'(lfsr_q[7:0] % div);
    assign rnd_start = (noise_thresh_i == 16'hFFFF) ||
                       (lfsr_q < noise_thresh_i);

    // Running results including the candidate on the inputs this cycle,
    // so the final pick is ready on the edge of the last accept.
    logic                   upd;
    logic                   rhit;
    logic [CNT_BITS-1:0]    cnt_inc;
    logic                   last;
    logic                   zero_now;
    logic [VAR_ID_BITS-1:0] bvar_now;
    logic [BV_BITS-1:0]     bbrk_now;
    logic [VAR_ID_BITS-1:0] rvar_now;
    logic [BV_BITS-1:0]     rbrk_now;

    assign upd      = (cnt_q == '0) || (cand_break_i < bbrk_q);
    assign rhit     = (cnt_q == ridx_q);
    assign cnt_inc  = cnt_q + CNT_BITS'(1);
    assign last     = (cnt_inc == n_q);
    assign zero_now = zero_q || (cand_break_i == '0);
    assign bvar_now = upd ? cand_var_i : bvar_q;
    assign bbrk_now = upd ? cand_break_i : bbrk_q;
    assign rvar_now = rhit ? cand_var_i : rvar_q;
    assign rbrk_now = rhit ? cand_break_i : rbrk_q;

    always_comb begin
        state_d = state_q;
        lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        n_d     = n_q;
        cnt_d   = cnt_q;
        ridx_d  = ridx_q;
        rnd_d   = rnd_q;
        zero_d  = zero_q;
        bvar_d  = bvar_q;
        bbrk_d  = bbrk_q;
        rvar_d  = rvar_q;
        rbrk_d  = rbrk_q;
        svar_d  = svar_q;
        sbrk_d  = sbrk_q;
        srnd_d  = srnd_q;
        unique case (state_q)
            IDLE: begin
                if (start_i && (num_cand_i != '0)) begin
                    state_d = SCAN;
                    n_d     = n_start;
                    ridx_d  = r_start;
                    rnd_d   = rnd_start;
                    cnt_d   = '0;
                    zero_d  = 1'b0;
                    bvar_d  = '0;
                    bbrk_d  = '0;
                    rvar_d  = '0;
                    rbrk_d  = '0;
                end
            end
            SCAN: begin
                if (cand_valid_i) begin
                    cnt_d  = cnt_inc;
                    zero_d = zero_now;
                    bvar_d = bvar_now;
                    bbrk_d = bbrk_now;
                    rvar_d = rvar_now;
                    rbrk_d = rbrk_now;
                    if (last) begin
                        state_d = DONE;
                        // A zero-break candidate wins over the noise pick.
                        if (!zero_now && rnd_q) begin
                            svar_d = rvar_now;
                            sbrk_d = rbrk_now;
                            srnd_d = 1'b1;
                        end else begin
                            svar_d = bvar_now;
                            sbrk_d = bbrk_now;
                            srnd_d = 1'b0;
                        end
                    end
                end
            end
            DONE: begin
                if (sel_ready_i) begin
                    state_d = IDLE;
                    svar_d  = '0;
                    sbrk_d  = '0;
                    srnd_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            n_q     <= '0;
            cnt_q   <= '0;
            ridx_q  <= '0;
            rnd_q   <= 1'b0;
            zero_q  <= 1'b0;
            bvar_q  <= '0;
            bbrk_q  <= '0;
            rvar_q  <= '0;
            rbrk_q  <= '0;
            svar_q  <= '0;
            sbrk_q  <= '0;
            srnd_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            ridx_q  <= ridx_d;
            rnd_q   <= rnd_d;
            zero_q  <= zero_d;
            bvar_q  <= bvar_d;
            bbrk_q  <= bbrk_d;
            rvar_q  <= rvar_d;
            rbrk_q  <= rbrk_d;
            svar_q  <= svar_d;
            sbrk_q  <= sbrk_d;
            srnd_q  <= srnd_d;
        end
    end

    assign cand_ready_o = (state_q == SCAN);
    assign sel_valid_o  = (state_q == DONE);
    assign busy_o       = (state_q != IDLE);
    assign sel_var_o    = svar_q;
    assign sel_break_o  = sbrk_q;
    assign sel_random_o = srnd_q;

endmodule
